// File: rtl/pulse_window_ctrl_if.sv
// Handshake/bus bundle between the control block, the pulse detector and pulse_window_ctrl.
// slave = the window controller's view, master = the driver (register block / bench) view.
interface pulse_window_if #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
);
    logic             start;
    logic             abort;
    logic [WIN_W-1:0] window_len;
    logic [CNT_W-1:0] threshold;
    logic             det_pulse;
    logic             irq_clr;
    logic             det_clr;
    logic             det_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulse_cnt;
    logic             sat;
    logic             irq;

    modport slave (
        input  start, abort, window_len, threshold, det_pulse, irq_clr,
        output det_clr, det_en, busy, done, pulse_cnt, sat, irq
    );

    modport master (
        output start, abort, window_len, threshold, det_pulse, irq_clr,
        input  det_clr, det_en, busy, done, pulse_cnt, sat, irq
    );
endinterface

// File: rtl/pulse_window_ctrl.sv
// Flush / count / report sequencer for one pulse detector over an N-cycle window.
// Optional macro PULSE_WINDOW_AUTO_RESTART_EN: DONE re-enters FLUSH for back-to-back windows.
module pulse_window_ctrl #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pulse_window_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    state_t           state_q, state_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [WIN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic [CNT_W-1:0] live_cnt_q, live_cnt_d;
    logic             live_sat_q, live_sat_d;
    logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic             sat_q, sat_d;
    logic             irq_q, irq_d;
    logic             enter_done;
    logic             irq_set;

    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        len_d       = len_q;
        thr_d       = thr_q;
        live_cnt_d  = live_cnt_q;
        live_sat_d  = live_sat_q;
        pulse_cnt_d = pulse_cnt_q;
        sat_d       = sat_q;
        enter_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    len_d      = bus.window_len;
                    thr_d      = bus.threshold;
                    live_cnt_d = '0;
                    live_sat_d = 1'b0;
                    state_d    = FLUSH;
                end
            end
            FLUSH: begin
                win_cnt_d = len_q;
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (len_q != '0) begin
                    state_d = COUNT;
                end else begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end
            end
            COUNT: begin
                // sat flags a pulse that arrived with the counter already pinned at all-ones
                if (bus.det_pulse) begin
                    if (live_cnt_q == CNT_MAX) begin
                        live_sat_d = 1'b1;
                    end else begin
                        live_cnt_d = live_cnt_q + 1'b1;
                    end
                end
                win_cnt_d = win_cnt_q - 1'b1;
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (win_cnt_q == WIN_ONE) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end
            end
            DONE: begin
`ifdef PULSE_WINDOW_AUTO_RESTART_EN
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    live_cnt_d = '0;
                    live_sat_d = 1'b0;
                    state_d    = FLUSH;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        // Results are captured on the edge that enters DONE, including the final COUNT cycle.
        if (enter_done) begin
            pulse_cnt_d = live_cnt_d;
            sat_d       = live_sat_d;
        end
    end

    assign irq_set = enter_done && (live_cnt_d >= thr_q);

    always_comb begin
        irq_d = irq_q;
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (bus.irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            win_cnt_q   <= '0;
            len_q       <= '0;
            thr_q       <= '0;
            live_cnt_q  <= '0;
            live_sat_q  <= 1'b0;
            pulse_cnt_q <= '0;
            sat_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            len_q       <= len_d;
            thr_q       <= thr_d;
            live_cnt_q  <= live_cnt_d;
            live_sat_q  <= live_sat_d;
            pulse_cnt_q <= pulse_cnt_d;
            sat_q       <= sat_d;
            irq_q       <= irq_d;
        end
    end

    assign bus.det_clr   = (state_q == FLUSH);
    assign bus.det_en    = (state_q == COUNT);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.pulse_cnt = pulse_cnt_q;
    assign bus.sat       = sat_q;
    assign bus.irq       = irq_q;
endmodule

// File: tb/tb_pulse_window_ctrl.sv
// Self-checking bench for pulse_window_ctrl: directed vector table, hand sequences and random windows.
// A window-level model derives expected outputs from the documented cycle timing.
module tb_pulse_window_ctrl;
    localparam int CNT_W = 8;
    localparam int WIN_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    pulse_window_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

    pulse_window_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model of the architecturally visible result registers
    int exp_cnt = 0;
    int exp_sat = 0;
    int exp_irq = 0;

    typedef struct {
        int          len;
        int          thr;
        logic [31:0] mask;       // bit i: pulse in COUNT cycle i
        bit          pall;       // pulse on every COUNT cycle
        int          abort_at;   // interval index carrying abort, -1 = none
        bit          clr_before;
        bit          clr_hold;
        int          exp_done;
        int          exp_cnt;
        int          exp_sat;
        int          exp_irq;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " det_clr"},   int'(bus.det_clr),   0);
        check({tag, " det_en"},    int'(bus.det_en),    0);
        check({tag, " busy"},      int'(bus.busy),      0);
        check({tag, " done"},      int'(bus.done),      0);
        check({tag, " pulse_cnt"}, int'(bus.pulse_cnt), 0);
        check({tag, " sat"},       int'(bus.sat),       0);
        check({tag, " irq"},       int'(bus.irq),       0);
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.det_pulse = 1'b0;
        bus.irq_clr   = 1'b0;
    endtask

    // Runs one window starting from IDLE at a negedge. Interval t lies between edge t-1 and t;
    // start is accepted at edge 0, so FLUSH=1, COUNT=2..len+1, DONE=len+2.
    task automatic run_window(input int len, input int thr, input logic [31:0] mask,
                              input bit pall, input int abort_at, input bit clr_before,
                              input bit clr_hold, input bit rnd,
                              output int got_done, output int got_cnt,
                              output int got_sat, output int got_irq);
        int  sum;
        bit  aborted;
        bit  in_count;
        bit  dp;
        bit  clr;
        int  last_t;
        sum      = 0;
        aborted  = 1'b0;
        got_done = 0;
        got_cnt  = int'(bus.pulse_cnt);
        got_sat  = int'(bus.sat);
        got_irq  = int'(bus.irq);
        last_t   = len + 2;
        if (clr_before) begin
            bus.irq_clr = 1'b1;
            @(negedge clk);
            exp_irq     = 0;
            bus.irq_clr = 1'b0;
        end
        for (int t = 0; t <= last_t + 1; t++) begin
            if (t >= 1) begin
                check("det_clr", int'(bus.det_clr), int'(!aborted && t == 1));
                check("det_en",  int'(bus.det_en),  int'(!aborted && t >= 2 && t <= len + 1));
                check("done",    int'(bus.done),    int'(!aborted && t == len + 2));
                check("busy",    int'(bus.busy),    int'(!aborted && t <= len + 2));
                check("pulse_cnt", int'(bus.pulse_cnt), exp_cnt);
                check("sat",       int'(bus.sat),       exp_sat);
                check("irq",       int'(bus.irq),       exp_irq);
                if (got_done == 0) begin
                    got_cnt = int'(bus.pulse_cnt);
                    got_sat = int'(bus.sat);
                    got_irq = int'(bus.irq);
                end
                if (bus.done) got_done = 1;
            end
            if (aborted || t == last_t + 1) break;

            in_count = (t >= 2 && t <= len + 1);
            if (t == 0) begin
                bus.start      = 1'b1;
                bus.window_len = WIN_W'(len);
                bus.threshold  = CNT_W'(thr);
            end else begin
                bus.start = (t <= len + 1) ? (rnd ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
                if (rnd) begin
                    bus.window_len = WIN_W'($urandom);
                    bus.threshold  = CNT_W'($urandom);
                end
            end
            bus.abort = (t == abort_at);
            if (in_count)
                dp = rnd ? 1'($urandom_range(0, 1)) : (pall || ((t - 2) < 32 && mask[t - 2]));
            else
                dp = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.det_pulse = dp;
            clr = clr_hold ? 1'b1 : (rnd ? ($urandom_range(0, 9) == 0) : 1'b0);
            bus.irq_clr = clr;
            @(negedge clk);

            if (in_count && dp) sum++;
            if (t == abort_at) aborted = 1'b1;
            if (!aborted && t == len + 1) begin
                exp_cnt = (sum > CMAX) ? CMAX : sum;
                exp_sat = (sum > CMAX) ? 1 : 0;
                if (exp_cnt >= thr) exp_irq = 1;
                else if (clr) exp_irq = 0;
            end else if (clr) begin
                exp_irq = 0;
            end
        end
        idle_inputs();
        $display("[TB] window len=%0d thr=%0d abort_at=%0d done=%0d cnt=%0d sat=%0d irq=%0d",
                 len, thr, abort_at, got_done, got_cnt, got_sat, got_irq);
    endtask

    initial begin
        int gd, gc, gs, gi;
        int len, thr, ab;

        idle_inputs();
        bus.window_len = '0;
        bus.threshold  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("in_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle busy", int'(bus.busy), 0);
            check("idle done", int'(bus.done), 0);
        end
        check_zero_outputs("after_reset");

`ifdef PULSE_WINDOW_AUTO_RESTART_EN
        for (int t = 0; t <= 20; t++) begin
            if (t >= 1) begin
                check("ar done", int'(bus.done), int'(t >= 6 && ((t - 6) % 6) == 0));
                check("ar busy", int'(bus.busy), 1);
                check("ar det_en", int'(bus.det_en), int'(((t - 1) % 6) >= 1 && ((t - 1) % 6) <= 4));
            end
            bus.start      = (t == 0);
            bus.window_len = WIN_W'(4);
            bus.threshold  = '0;
            bus.abort      = (t == 20);
            @(negedge clk);
        end
        idle_inputs();
        for (int i = 0; i < 15; i++) begin
            check("ar after abort busy", int'(bus.busy), 0);
            check("ar after abort done", int'(bus.done), 0);
            @(negedge clk);
        end
        $display("[TB] auto-restart windows checked");
`else
        //                 len  thr  mask   pall abort clrb clrh | done cnt sat irq
        vecs[0]  = '{  0,   5, 32'h0,  1'b0, -1, 1'b1, 1'b0,  1,   0,  0,  0};
        vecs[1]  = '{  1,   1, 32'h1,  1'b0, -1, 1'b0, 1'b0,  1,   1,  0,  1};
        vecs[2]  = '{ 10,   3, 32'h55, 1'b0, -1, 1'b1, 1'b0,  1,   4,  0,  1};
        vecs[3]  = '{ 10,   5, 32'h55, 1'b0, -1, 1'b1, 1'b0,  1,   4,  0,  0};
        vecs[4]  = '{300, 255, 32'h0,  1'b1, -1, 1'b1, 1'b0,  1, 255,  1,  1};
        vecs[5]  = '{  5,   0, 32'h0,  1'b0, -1, 1'b1, 1'b0,  1,   0,  0,  1};
        vecs[6]  = '{ 10,   0, 32'h0,  1'b1,  6, 1'b1, 1'b0,  0,   0,  0,  0};
        vecs[7]  = '{  8,   8, 32'hFF, 1'b0, -1, 1'b1, 1'b0,  1,   8,  0,  1};
        vecs[8]  = '{  8,   9, 32'hFF, 1'b0, -1, 1'b1, 1'b0,  1,   8,  0,  0};
        vecs[9]  = '{  4,   0, 32'h0,  1'b0,  1, 1'b0, 1'b0,  0,   8,  0,  0};
        vecs[10] = '{  2,   1, 32'h2,  1'b0, -1, 1'b1, 1'b0,  1,   1,  0,  1};
        vecs[11] = '{  3,   0, 32'h0,  1'b0, -1, 1'b0, 1'b1,  1,   0,  0,  1};

        for (int v = 0; v < 12; v++) begin
            run_window(vecs[v].len, vecs[v].thr, vecs[v].mask, vecs[v].pall, vecs[v].abort_at,
                       vecs[v].clr_before, vecs[v].clr_hold, 1'b0, gd, gc, gs, gi);
            check($sformatf("vec%0d done", v), gd, vecs[v].exp_done);
            check($sformatf("vec%0d cnt", v),  gc, vecs[v].exp_cnt);
            check($sformatf("vec%0d sat", v),  gs, vecs[v].exp_sat);
            check($sformatf("vec%0d irq", v),  gi, vecs[v].exp_irq);
            @(negedge clk);
        end

        // asynchronous reset in the middle of a window
        bus.start      = 1'b1;
        bus.window_len = WIN_W'(20);
        bus.threshold  = '0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid busy before reset", int'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        exp_sat = 0;
        exp_irq = 0;
        repeat (3) begin
            @(negedge clk);
            check_zero_outputs("post_mid_reset");
        end
        $display("[TB] mid-window reset checked");

        for (int r = 0; r < 40; r++) begin
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(3, 40);
            thr = $urandom_range(0, 24);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 1) : -1;
            run_window(len, thr, 32'h0, 1'b0, ab, 1'b0, 1'b0, 1'b1, gd, gc, gs, gi);
            check("rnd done seen", gd, int'(ab < 0));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("rnd idle busy", int'(bus.busy), 0);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pulse_window_ctrl.md
Name: pulse_window_ctrl

Overview:
Sequences the serial pulse detector over a programmable measurement window. It flushes the detector, enables it for exactly N cycles, and counts the single-cycle detect strobes it returns. At window end it latches the count, compares it against a threshold and raises a sticky interrupt. It sits between the control/register block and one pulse-detect instance.

Parameters:
CNT_W, 8, width of pulse counter and threshold
WIN_W, 16, width of window length / window counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request to begin a window; sampled only in IDLE
abort  in  1  cancel the current window; return to IDLE with no done pulse
window_len  in  WIN_W  window length in cycles; sampled on accepted start
threshold  in  CNT_W  irq threshold; sampled on accepted start
det_pulse  in  1  detect strobe from the pulse detector; one count per high cycle
irq_clr  in  1  clears sticky irq
det_clr  out  1  flush the detector state; high in FLUSH only
det_en  out  1  gate the detector data input; high in COUNT only
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse in DONE
pulse_cnt  out  CNT_W  latched count of the last completed window
sat  out  1  last completed window saturated the counter
irq  out  1  sticky: last completed count >= threshold

Behaviour:
- Reset (async, rst_n=0): state=IDLE; window counter, live counter, pulse_cnt, sat, irq, latched window_len and latched threshold all = 0. det_clr, det_en, busy and done are decoded from state, so all are 0.
- The FSM is registered. det_clr, det_en, busy and done are pure decodes of the state.
- IDLE: if start=1 and abort=0 at a clock edge, latch window_len and threshold, clear the live count, and go to FLUSH. Otherwise stay in IDLE.
- FLUSH: lasts exactly 1 cycle with det_clr=1. Load the window counter with the latched length. Next state is COUNT if the length is nonzero, else DONE.
- COUNT: lasts exactly window_len cycles with det_en=1.
  - Each cycle with det_pulse=1 increments the live count.
  - At all-ones the live count saturates and the internal sat flag is set.
  - The window counter decrements each cycle. Move to DONE on the cycle it holds 1.
  - det_pulse is ignored in all states except COUNT.
- DONE: lasts 1 cycle with done=1. On entering DONE, pulse_cnt is loaded with the live count and sat with the saturation flag. Next state is IDLE.
- Latency: start accepted at edge k gives FLUSH at k+1, COUNT from k+2 to k+1+N, and DONE at k+2+N. pulse_cnt and sat are valid in the same cycle as done.
- irq:
  - Set on the DONE entry edge if the captured count >= the latched threshold. A threshold of 0 always sets irq.
  - Cleared by irq_clr=1 while it is not being set.
  - Simultaneous set and irq_clr: set wins.
  - irq is not cleared by a new start.
- abort=1 in FLUSH or COUNT: next state is IDLE. No done pulse; pulse_cnt, sat and irq are unchanged. abort has priority over start in IDLE and over the DONE transition.
- start while busy: ignored. It is not queued.
- window_len=0: the sequence is FLUSH then DONE, with count=0 and sat=0.
- Reset mid-window: immediate return to the reset values; no done pulse.

Optional Feature:
PULSE_WINDOW_AUTO_RESTART_EN.
- Defined: DONE goes directly to FLUSH, re-using the latched window_len and threshold. This gives back-to-back windows with a 1-cycle flush gap; busy stays high. A cycle with abort=1 returns the FSM to IDLE. A start is accepted only from IDLE.
- Not defined: DONE always returns to IDLE.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then release -> all outputs 0; start=0 keeps busy=0 indefinitely.
- Basic window: window_len=10, threshold=3, det_pulse high on 4 separate COUNT cycles -> det_clr high 1 cycle, det_en high exactly 10 cycles, done at start+12, pulse_cnt=4, irq=1.
- Saturation: CNT_W=8, window_len=300, det_pulse held at 1 -> pulse_cnt=255, sat=1.
- Edge lengths: window_len=0 -> done 2 cycles after start, pulse_cnt=0. window_len=1 -> det_en high 1 cycle.
- Abort and collisions:
  - abort in COUNT cycle 5 -> busy drops the next cycle, no done, pulse_cnt keeps its previous value.
  - start while busy -> ignored.
  - irq_clr in the same cycle as an irq set -> irq=1.
- Auto-restart (macro defined): window_len=4, start once -> done every 6 cycles; abort -> IDLE, no further done.
